// File: rtl/uart_transmission.sv
// UART transmitter: sends one byte as an 11-bit frame (start, 8 data LSB first, even parity, stop).
// Each frame bit is held for 16 pulses of the 16x oversampling enable.
module uart_transmission (
   input  logic       clk,
   input  logic       reset,
   input  logic       Tx_EN,
   input  logic       Tx_WR,
   input  logic [7:0] Tx_DATA,
   input  logic       Tx_sample_ENABLE,
   output logic       TxD,
   output logic       Tx_BUSY,
   output logic       Tx_DONE
);

   localparam int unsigned FRAME_W = 11;
   localparam int unsigned CNT_W   = 4;
   localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(15);
   localparam logic [CNT_W-1:0] LAST_BIT    = CNT_W'(10);

   typedef enum logic {IDLE, SEND} state_t;

   state_t             state;
   logic [FRAME_W-1:0] frame;
   logic [CNT_W-1:0]   sample_cnt;
   logic [CNT_W-1:0]   bit_idx;

   // frame[0] is always the bit currently on the line; the register shifts right per bit
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         frame      <= '1;
         sample_cnt <= '0;
         bit_idx    <= '0;
         TxD        <= 1'b1;
         Tx_BUSY    <= 1'b0;
         Tx_DONE    <= 1'b0;
      end else begin
         Tx_DONE <= 1'b0;
         case (state)
            IDLE: begin
               TxD     <= 1'b1;
               Tx_BUSY <= 1'b0;
               if (Tx_WR && Tx_EN) begin
                  frame      <= {1'b1, ^Tx_DATA, Tx_DATA, 1'b0};
                  sample_cnt <= '0;
                  bit_idx    <= '0;
                  TxD        <= 1'b0;
                  Tx_BUSY    <= 1'b1;
                  state      <= SEND;
               end
            end
            SEND: begin
               if (!Tx_EN) begin
                  state      <= IDLE;
                  frame      <= '1;
                  sample_cnt <= '0;
                  bit_idx    <= '0;
                  TxD        <= 1'b1;
                  Tx_BUSY    <= 1'b0;
               end else if (Tx_sample_ENABLE) begin
                  if (sample_cnt == LAST_SAMPLE) begin
                     sample_cnt <= '0;
                     if (bit_idx == LAST_BIT) begin
                        state   <= IDLE;
                        frame   <= '1;
                        bit_idx <= '0;
                        TxD     <= 1'b1;
                        Tx_BUSY <= 1'b0;
                        Tx_DONE <= 1'b1;
                     end else begin
                        bit_idx <= bit_idx + CNT_W'(1);
                        frame   <= {1'b1, frame[FRAME_W-1:1]};
                        TxD     <= frame[1];
                     end
                  end else begin
                     sample_cnt <= sample_cnt + CNT_W'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/uart_transmission.md
# uart_transmission

UART transmitter: serializes one 8-bit byte per request into an 11-bit frame on TxD. Each bit is held for 16 pulses of the baud-controller oversampling enable, which is the same 16x rate the receiver uses. The frame layout matches the receiver's bit ordering, so a TxD-to-RxD loopback reproduces the byte. It sits between the host-side write interface and the serial line, next to the shared baud controller.

## Interface
- No parameters. Frame format and oversampling ratio are fixed.
- clk  input  1  system clock; all state changes on its rising edge
- reset  input  1  asynchronous, active-low reset
- Tx_EN  input  1  transmitter enable; level-sensitive
- Tx_WR  input  1  write strobe, one clk wide; requests transmission of Tx_DATA
- Tx_DATA  input  8  byte to send; sampled only on an accepted Tx_WR
- Tx_sample_ENABLE  input  1  16x-baud enable from baud controller, one clk wide per pulse
- TxD  output  1  serial line; idles high
- Tx_BUSY  output  1  high while a frame is in progress
- Tx_DONE  output  1  one-clk pulse when the stop bit completes

## Operation
- Frame bit index 0..10:
  - 0: start bit (0)
  - 1..8: Tx_DATA[0]..Tx_DATA[7], LSB first
  - 9: even parity, the XOR of Tx_DATA[7:0]
  - 10: stop bit (1)
- Internal registers:
  - 11-bit frame shift register, loaded on accept
  - 4-bit sample counter (0..15)
  - 4-bit bit index (0..10)
- States: IDLE, SEND.
- IDLE:
  - TxD=1, Tx_BUSY=0.
  - A write is accepted when Tx_WR=1, Tx_EN=1 and Tx_BUSY=0.
  - On accept: latch the frame, set bit index=0 and sample counter=0, go to SEND.
- SEND:
  - TxD = frame[bit index].
  - Each Tx_sample_ENABLE pulse increments the sample counter.
  - On a pulse with counter==15: the counter wraps to 0 and the bit index increments.
  - On a pulse with counter==15 and bit index==10: go to IDLE and pulse Tx_DONE.
- Tx_WR while Tx_BUSY=1, or while Tx_EN=0: ignored. No queueing, and Tx_DATA is not re-sampled.
- Tx_DATA may change at any time after acceptance without affecting the frame in flight.
- Tx_EN dropping to 0 during SEND aborts the frame:
  - Go to IDLE on the next edge with TxD=1 and Tx_BUSY=0.
  - Tx_DONE is not pulsed.
  - Counters are cleared.
- Simultaneous accept and Tx_sample_ENABLE in the same cycle: the pulse is not counted. The start bit's 16 pulses begin after acceptance.
- Tx_sample_ENABLE pulses while in IDLE: no effect.

## Timing
- Reset (asynchronous assertion, any state): TxD=1, Tx_BUSY=0, Tx_DONE=0, state IDLE, counters 0.
- Reset release: synchronous to clk. The first accept is possible on the first edge with reset=1.
- Accept at edge N: TxD=0 and Tx_BUSY=1 are visible after edge N (one-clk latency).
- Bit duration: exactly 16 Tx_sample_ENABLE pulses.
- Frame length: exactly 176 pulses from accept to return to IDLE.
- TxD changes only on the clk edge that consumes the 16th pulse of a bit, so it is glitch-free and registered.
- On the edge consuming the 176th pulse: Tx_BUSY falls, TxD stays 1, and Tx_DONE is high for that one cycle.
- Back-to-back frames: Tx_WR in the cycle after Tx_BUSY falls is accepted. The minimum inter-frame gap is one clk of idle high beyond the stop bit.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset: hold reset=0 with random inputs -> TxD=1, Tx_BUSY=0, Tx_DONE=0 throughout; assert reset mid-frame -> TxD=1 immediately.
- Send 0xA5 with Tx_sample_ENABLE every 4 clk:
  - TxD bit sequence 0,1,0,1,0,0,1,0,1,0,1, each held 64 clk.
  - Tx_BUSY high for 704 clk; one Tx_DONE pulse.
- Send 0x07 -> parity bit 1; the full sequence 0,1,1,1,0,0,0,0,0,1,1 is decoded by the loopback receiver as 0x07 with no framing error.
- Tx_WR with 0x3C issued while busy sending 0x55 -> only 0x55 is transmitted; the next Tx_WR after Tx_DONE sends its byte normally.
- Tx_EN dropped after bit 4 -> TxD=1 and Tx_BUSY=0 on the next edge, no Tx_DONE; Tx_WR with Tx_EN=0 -> no start bit.
- Tx_WR coincident with a Tx_sample_ENABLE pulse -> start bit still lasts exactly 16 pulses; back-to-back writes of 0x00 and 0xFF give two correct frames separated by ≥1 clk of high line.
